enc_8to3_seq: RTL
=================

// Module: enc_8to3_seq
// PURPOSE
// - Sequential 8-to-3 encoder. It is the inverse companion of the 3-to-8 decoder.
// - Latches an 8-bit request vector (in0..in7) on an input handshake.
// - Streams the 3-bit index of every set bit, one beat per accepted output handshake.
// - Used wherever a multi-hot flag vector must be serialised into binary indices
//   for a downstream 3-to-8 decode stage.
// PARAMETERS
// - LSB_FIRST  1  1: emit lowest set index first; 0: emit highest set index first.
// PORTS
// - clk        in   1  Single clock; all state updates on the rising edge.
// - rst_n      in   1  Reset, asynchronous, active-low.
// - en         in   1  Block enable. Low: inputs ignored; an active stream is aborted.
// - in_valid   in   1  Request vector on in0..in7 is valid.
// - in_ready   out  1  Block can accept a vector. High only in IDLE.
// - in0..in7   in   1  Request bits; in0 is index 0.
// - out_valid  out  1  out2..out0, last, none and beat are valid.
// - out_ready  in   1  Downstream accepts the current beat.
// - out0..out2 out  1  Encoded index {out2,out1,out0} of the current set bit.
// - last       out  1  Current beat is the final beat of this vector.
// - none       out  1  Latched vector was all-zero. Single beat; code 3'b000.
// - beat       out  3  Zero-based ordinal of the current beat within the vector.
// BEHAVIOUR
// - Reset values (async, take effect immediately):
//   - state = IDLE, pend = 8'h00, beat = 0.
//   - out_valid = 0, code = 0, last = 0, none = 0, in_ready = 1.
// - Outputs are decoded from registered state only. There is no input-to-output
//   combinational path.
// - FSM:
//   - IDLE:
//     - in_ready = 1, out_valid = 0.
//     - If en & in_valid: pend <= {in7..in0}, beat <= 0, go to EMIT.
//   - EMIT:
//     - in_ready = 0, out_valid = 1.
//     - code = priority index of pend, chosen per LSB_FIRST.
//     - last = (popcount(pend) <= 1).
//     - none = (pend == 0).
//   - Handshake in EMIT (out_valid & out_ready & en):
//     - If last: pend <= 0, beat <= 0, go to IDLE.
//     - Else: clear the emitted bit in pend, beat <= beat + 1.
//   - Abort: en low in EMIT clears pend and beat and returns to IDLE on the next
//     edge. out_ready in that cycle is ignored, and no beat counts as accepted.
// - Latency: vector accepted at edge N gives out_valid = 1 from cycle N+1.
// - A vector with k set bits yields k beats; an all-zero vector yields 1 beat.
// - Minimum occupancy: k+1 cycles per vector. in_ready returns the cycle after
//   the last handshake.
// - Backpressure: while out_valid & !out_ready, code, last, none and beat are held
//   stable.
// - beat never wraps: at most 8 beats, values 0..7.
// - in_valid, and the in0..in7 values, are don't-care outside IDLE. No
//   back-to-back overlap is allowed.
// STRUCTURE
// - Shared include (dec_enc_defs.vh): state encodings ST_IDLE = 1'b0 and
//   ST_EMIT = 1'b1.
// - Sub-module pri_enc_8to3: combinational 8-bit priority encoder with a
//   LSB_FIRST parameter. Outputs a 3-bit index and an any flag. Instantiated once
//   on pend.
// - Top level holds the FSM, the pend register, the beat counter and the
//   popcount<=1 detect.
// TESTING
// - T1: LSB_FIRST=1, load 8'b1010_0100, out_ready=1.
//   -> codes 2, 5, 7 on consecutive cycles; beat 0, 1, 2; last only on code 7;
//   in_ready=1 the next cycle.
// - T2: load 8'h00.
//   -> exactly one beat with none=1, last=1, code=0; then IDLE.
// - T3: load 8'b0001_0010; hold out_ready=0 for 3 cycles.
//   -> code=1, beat=0, last=0 stable throughout; then codes 1, 4 once out_ready=1.
// - T4: LSB_FIRST=0, load 8'hFF, out_ready=1.
//   -> codes 7..0, beats 0..7, last on code 0; 9 cycles from load to in_ready.
// - T5: load 8'h0F; drop en after the first beat.
//   -> out_valid=0 and in_ready=1 the next cycle; the following load 8'h80 emits
//   only code 7.
// - T6: assert rst_n=0 mid-EMIT between clock edges.
//   -> out_valid=0, in_ready=1, beat=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/enc_8to3_seq_pkg.sv
// Shared definitions for the sequential 8-to-3 encoder.
//   VEC_W / IDX_W  : request vector width and encoded index width
//   ST_IDLE/ST_EMIT: FSM state codes, matching the legacy decoder/encoder defs
//   at_most_one()  : true when a vector has zero or one bit set
package enc_8to3_seq_pkg;

    localparam int unsigned VEC_W   = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned STATE_W = 1;

    localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] ST_EMIT = 1'b1;

    // Clearing the lowest set bit leaves zero only if at most one bit was set.
    function automatic logic at_most_one(input logic [VEC_W-1:0] v);
        return (v & (v - VEC_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/enc_8to3_seq_pri_enc.sv
// Combinational 8-bit priority encoder.
//   vec : request vector (bit 0 is index 0)
//   idx : index of the winning set bit; 0 when vec is all-zero
//   any : at least one bit of vec is set
// LSB_FIRST=1 picks the lowest set index, LSB_FIRST=0 the highest.
module pri_enc_8to3
    import enc_8to3_seq_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [VEC_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan towards the preferred end so the preferred bit is written last.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            if (LSB_FIRST) begin
                if (vec[IDX_W'(VEC_W - 1 - i)]) idx = IDX_W'(VEC_W - 1 - i);
            end else begin
                if (vec[IDX_W'(i)]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/enc_8to3_seq.sv
// Sequential 8-to-3 encoder: latches a multi-hot request vector on an input
// handshake and streams the index of each set bit, one beat per output
// handshake. An all-zero vector yields a single beat flagged with none.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : block enable; low aborts an active stream
//   in_valid, in_ready  : input handshake; in0..in7 are the request bits
//   out_valid, out_ready: output handshake
//   out2..out0          : encoded index of the current beat
//   last, none, beat    : final-beat flag, all-zero flag, beat ordinal
// All outputs are decoded from registered state only.
module enc_8to3_seq
    import enc_8to3_seq_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       in4,
    input  logic       in5,
    input  logic       in6,
    input  logic       in7,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out0,
    output logic       out1,
    output logic       out2,
    output logic       last,
    output logic       none,
    output logic [2:0] beat
);

    logic [STATE_W-1:0] state;
    logic [VEC_W-1:0]   pend;
    logic [IDX_W-1:0]   beat_q;
    logic [IDX_W-1:0]   code;
    logic               any;
    logic               single;
    logic               emit;
    logic               take;

    pri_enc_8to3 #(
        .LSB_FIRST(LSB_FIRST)
    ) u_pri (
        .vec(pend),
        .idx(code),
        .any(any)
    );

    assign emit   = (state == ST_EMIT);
    assign single = at_most_one(pend);
    assign take   = emit & en & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pend   <= '0;
            beat_q <= '0;
        end else if (!emit) begin
            if (en && in_valid) begin
                state  <= ST_EMIT;
                pend   <= {in7, in6, in5, in4, in3, in2, in1, in0};
                beat_q <= '0;
            end
        end else if (!en || (take && single)) begin
            // Abort and final handshake both leave pend clear, so IDLE
            // outputs (code, last, none) fall back to zero.
            state  <= ST_IDLE;
            pend   <= '0;
            beat_q <= '0;
        end else if (take) begin
            pend   <= pend & ~(VEC_W'(1) << code);
            beat_q <= beat_q + IDX_W'(1);
        end
    end

    assign in_ready          = ~emit;
    assign out_valid         = emit;
    assign {out2, out1, out0} = code;
    assign last              = emit & single;
    assign none              = emit & ~any;
    assign beat              = beat_q;

endmodule
